// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared types and decode helpers for the load/store unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_RD     = 3'd2,
        S_RESP   = 3'd3,
        S_RMW_RD = 3'd4,
        S_MERGE  = 3'd5
    } lsu_state_t;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2
    } lsu_width_t;

    localparam logic [2:0] C_F3_LB      = 3'b000;
    localparam logic [2:0] C_F3_LH      = 3'b001;
    localparam int         C_F3_UNS_BIT = 2;

    function automatic lsu_width_t funct3_width(input logic [2:0] funct3);
        lsu_width_t w;
        if (funct3[1:0] == C_F3_LB[1:0]) begin
            w = W_BYTE;
        end else if (funct3[1:0] == C_F3_LH[1:0]) begin
            w = W_HALF;
        end else begin
            w = W_WORD;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : lane extract with sign/zero extension, and sub-word merge
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  lsu_width_t  i_width,
    input  logic        i_unsigned,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // Halfword lane uses only lane[1], so an odd half address folds down.
        w_byte   = i_word[{i_lane, 3'b000} +: 8];
        w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_width)
            W_BYTE: begin
                o_load   = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                o_merged = i_word;
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            W_HALF: begin
                o_load   = {{16{~i_unsigned & w_half[15]}}, w_half};
                o_merged = i_word;
                o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV32I MEM-stage initiator for a word-wide data RAM
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned requests
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic [ADDR_W-1:0] data_memory_address,
    output logic [31:0]       data_memory_data_in,
    output logic              store,
    output logic              load,
    input  logic [31:0]       data_memory_data_out
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    lsu_width_t        width_q, width_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;

    lsu_width_t        w_req_width;
    logic              w_mis;
    logic              w_accept;
    logic [31:0]       w_load_ext;
    logic [31:0]       w_merged;
    logic [31:0]       w_unused_load_merge;
    logic [31:0]       w_unused_merge_load;
    logic              w_unused_addr_hi;

    assign w_req_width      = funct3_width(req_funct3);
    assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];

    always_comb begin
        w_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        w_mis = ((w_req_width == W_HALF) && req_addr[0]) ||
                ((w_req_width == W_WORD) && (req_addr[1:0] != 2'b00));
`endif
    end

    assign w_accept = (state_q == S_IDLE) && req_valid && !w_mis;

    lsu_align u_load_align (
        .i_width    (width_q),
        .i_unsigned (uns_q),
        .i_lane     (lane_q),
        .i_word     (data_memory_data_out),
        .i_wdata    (32'h0),
        .o_load     (w_load_ext),
        .o_merged   (w_unused_load_merge)
    );

    lsu_align u_merge_align (
        .i_width    (width_q),
        .i_unsigned (uns_q),
        .i_lane     (lane_q),
        .i_word     (data_memory_data_out),
        .i_wdata    (wdata_q),
        .o_load     (w_unused_merge_load),
        .o_merged   (w_merged)
    );

    // RAM-facing ports come only from buffered state, never from req_*.
    assign data_memory_address = addr_q;
    assign data_memory_data_in = wdata_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        width_d    = width_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        stall      = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        case (state_q)
            S_IDLE: begin
                misaligned = req_valid && w_mis;
                stall      = w_accept;
                if (w_accept) begin
                    addr_d  = req_addr[ADDR_W+1:2];
                    lane_d  = req_addr[1:0];
                    width_d = w_req_width;
                    uns_d   = req_funct3[C_F3_UNS_BIT];
                    wdata_d = req_wdata;
                    if (!req_store) begin
                        state_d = S_RD;
                    end else if (w_req_width == W_WORD) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_WR: begin
                store   = 1'b1;
                state_d = S_IDLE;
            end
            S_RD: begin
                load    = 1'b1;
                stall   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                load_valid = 1'b1;
                load_data  = w_load_ext;
                state_d    = S_IDLE;
            end
            S_RMW_RD: begin
                load    = 1'b1;
                stall   = 1'b1;
                state_d = S_MERGE;
            end
            S_MERGE: begin
                stall   = 1'b1;
                wdata_d = w_merged;
                state_d = S_WR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= 2'b00;
            width_q <= W_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            width_q <= width_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

`default_nettype wire
